if_id_skid_pipe: RTL and testbench
==================================

# if_id_skid_pipe

Parametrised IF/ID pipeline register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush, and a saturating bubble counter. Sits between the fetch unit (upstream, `in_*`) and decode (downstream, `out_*`). Back-pressure from decode no longer drops or duplicates instructions, and branch resolution can squash in-flight fetches.

## Interface
Parameters:
- `INS_W`, default 32: instruction width.
- `PC_W`, default 32: PC width.
- `NOP`, default `32'h0000_0000` (width `INS_W`): instruction value presented when no valid entry is held.
- `SKID_EN`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, default 16: bubble counter width.

Ports (clock and reset first):
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: synchronous squash of all held entries.
- `in_valid`, input, 1: fetch offers an instruction.
- `in_ready`, output, 1: stage accepts this cycle.
- `in_ins`, input, `INS_W`: fetched instruction.
- `in_pc`, input, `PC_W`: PC of the fetched instruction.
- `out_valid`, output, 1: decode-side entry valid.
- `out_ready`, input, 1: decode consumes this cycle.
- `out_ins`, output, `INS_W`: head instruction; `NOP` when `out_valid`=0.
- `out_pc`, output, `PC_W`: head PC; 0 when `out_valid`=0.
- `bubble_cnt`, output, `CNT_W`: cycles with `out_valid`=0 since reset, saturating.

## Operation
- Transfer rules: upstream transfer when `in_valid && in_ready`; downstream transfer when `out_valid && out_ready`.
- States (`SKID_EN`=1):
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - FULL: main register valid, skid empty, `in_ready`=1.
  - SKID: main and skid both valid, `in_ready`=0.
- Transitions:
  - EMPTY + in → FULL.
  - FULL + in + out → FULL, with main loaded from the input.
  - FULL + out only → EMPTY.
  - FULL + in only (`out_ready`=0) → SKID, with the input captured in skid.
  - FULL, neither → FULL.
  - SKID + out → FULL, with main loaded from skid.
  - SKID, no out → SKID.
- `in_ready` is decoded from the state register only: `state != SKID`. It has no combinational path from `out_ready`.
- `SKID_EN`=0: single entry. `in_ready = !out_valid || out_ready` (combinational). The SKID state does not exist.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- Flush:
  - Next state EMPTY; both entries invalidated.
  - Any simultaneous input transfer is discarded.
  - A simultaneous output transfer still counts as consumed by decode this cycle.
- Reset:
  - State EMPTY; `out_valid`=0, `out_ins`=`NOP`, `out_pc`=0, `in_ready`=1, `bubble_cnt`=0.
  - Reset overrides flush and every handshake, including mid-SKID.
- `bubble_cnt`:
  - Increments by 1 on each non-reset edge where `out_valid` was 0 in that cycle, flush cycles included.
  - Holds at 2^`CNT_W`−1 once reached; never wraps.

## Timing
- Latency: an input accepted at edge N appears on `out_*` with `out_valid`=1 after edge N, when the stage was EMPTY or is draining.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- `in_ready` deasserts the cycle after the first stall that fills the skid; it reasserts the cycle after the first downstream transfer out of SKID.
- Flush effect is visible on outputs the cycle after `flush`=1: `out_valid`=0, `out_ins`=`NOP`.
- `out_*` are registered. Their only combinational input dependency is none.

## Structure
- Shared pipeline package holds the default `NOP` encoding, the state encoding constants (EMPTY=2'd0, FULL=2'd1, SKID=2'd2), and the default widths. Future ID_EX/EX_MEM successors reuse them.
- One natural sub-module: `skid_entry`, a valid plus data+PC register with load and clear. Instantiate it twice (main, skid); the skid instance is only generated when `SKID_EN`=1.
- Next-state and `bubble_cnt` logic stay in the top module.

## Test plan
- Reset then idle 5 cycles → `out_valid`=0, `out_ins`=`NOP`, `out_pc`=0, `in_ready`=1, `bubble_cnt`=5.
- Stream `ins`=0x00A00093,0x00B00113,0x00C00193 at PC 0x0,0x4,0x8 with `out_ready`=1 → the same three appear on consecutive cycles, one cycle later, in order.
- Stall: hold `out_ready`=0 after the first accept, keep offering 0x11,0x22,0x33 → 0x11 held on `out_*`, 0x22 captured in skid, `in_ready`=0; 0x33 is not accepted until `out_ready` returns. Output order is then 0x11,0x22,0x33 with no loss.
- Flush while in SKID with `in_valid`=1 → next cycle `out_valid`=0, state EMPTY, `in_ready`=1; the offered input never appears on `out_*`.
- `rst` asserted mid-stream while in SKID, together with `flush` → all outputs reach reset values on the next edge and `bubble_cnt`=0.
- `CNT_W`=3, hold `in_valid`=0 for 10 cycles → `bubble_cnt` reaches 7 and stays 7. Repeat the stall scenario with `SKID_EN`=0 → `in_ready` follows `out_ready` combinationally and no entry is lost.

Source files
------------

// File: rtl/if_id_skid_pipe_pkg.sv
// Shared pipeline package: default widths, NOP encoding and the
// handshake state encoding reused by the IF/ID stage and its successors.
package if_id_skid_pipe_pkg;

   localparam int PIPE_INS_W = 32;
   localparam int PIPE_PC_W  = 32;
   localparam int PIPE_CNT_W = 16;

   // Instruction presented downstream whenever no valid entry is held.
   localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/if_id_skid_pipe_skid_entry.sv
// One pipeline entry: a valid bit plus instruction/PC payload.
// Clear beats load so a flush always wins over a same-cycle capture.
module if_id_skid_pipe_skid_entry
   import if_id_skid_pipe_pkg::*;
#(
   parameter int               INS_W = PIPE_INS_W,
   parameter int               PC_W  = PIPE_PC_W,
   parameter logic [INS_W-1:0] NOP   = INS_W'(PIPE_NOP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [INS_W-1:0] d_ins,
   input  logic [PC_W-1:0]  d_pc,
   output logic             valid,
   output logic [INS_W-1:0] ins,
   output logic [PC_W-1:0]  pc
);

   // Entry register: emptied entries show NOP / PC 0 so downstream never sees stale data.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         valid <= 1'b0;
         ins   <= NOP;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ins   <= d_ins;
         pc    <= d_pc;
      end
   end

endmodule

// File: rtl/if_id_skid_pipe.sv
// IF/ID pipeline register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), synchronous flush and a saturating
// count of cycles in which decode saw no valid instruction.
module if_id_skid_pipe
   import if_id_skid_pipe_pkg::*;
#(
   parameter int               INS_W   = PIPE_INS_W,
   parameter int               PC_W    = PIPE_PC_W,
   parameter logic [INS_W-1:0] NOP     = INS_W'(PIPE_NOP),
   parameter int               SKID_EN = 1,
   parameter int               CNT_W   = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [INS_W-1:0] in_ins,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INS_W-1:0] out_ins,
   output logic [PC_W-1:0]  out_pc,
   output logic [CNT_W-1:0] bubble_cnt
);

   pipe_state_e      state_reg, state_next;
   logic             up_xfer, dn_xfer;

   logic             main_valid;
   logic [INS_W-1:0] main_ins;
   logic [PC_W-1:0]  main_pc;
   logic             main_load, main_clr;
   logic [INS_W-1:0] main_d_ins;
   logic [PC_W-1:0]  main_d_pc;

   logic             skid_valid;
   logic [INS_W-1:0] skid_ins;
   logic [PC_W-1:0]  skid_pc;

   logic [CNT_W-1:0] bubble_reg, bubble_next;

   assign up_xfer    = in_valid && in_ready;
   assign dn_xfer    = main_valid && out_ready;

   assign out_valid  = main_valid;
   assign out_ins    = main_ins;
   assign out_pc     = main_pc;
   assign bubble_cnt = bubble_reg;

   // State register; reset overrides flush and any handshake.
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ST_EMPTY;
      else
         state_reg <= state_next;
   end

   // Next-state: flush empties the stage, otherwise follow the handshake.
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: if (up_xfer) state_next = ST_FULL;
            ST_FULL: begin
               if (up_xfer && !dn_xfer && (SKID_EN != 0))
                  state_next = ST_SKID;
               else if (dn_xfer && !up_xfer)
                  state_next = ST_EMPTY;
            end
            ST_SKID:  if (dn_xfer) state_next = ST_FULL;
            default:  state_next = ST_EMPTY;
         endcase
      end
   end

   // Main-entry controls: refill from skid when it holds the older entry.
   always_comb begin
      main_load  = 1'b0;
      main_clr   = flush;
      main_d_ins = skid_valid ? skid_ins : in_ins;
      main_d_pc  = skid_valid ? skid_pc  : in_pc;
      case (state_reg)
         ST_EMPTY: main_load = up_xfer;
         ST_FULL: begin
            main_load = up_xfer && dn_xfer;
            if (dn_xfer && !up_xfer)
               main_clr = 1'b1;
         end
         ST_SKID:  main_load = dn_xfer;
         default:  main_clr  = 1'b1;
      endcase
   end

   if_id_skid_pipe_skid_entry #(
      .INS_W (INS_W),
      .PC_W  (PC_W),
      .NOP   (NOP)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .clr   (main_clr),
      .load  (main_load),
      .d_ins (main_d_ins),
      .d_pc  (main_d_pc),
      .valid (main_valid),
      .ins   (main_ins),
      .pc    (main_pc)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         logic skid_load, skid_clr;

         // Skid captures the input only when main is held by a stalled decode.
         always_comb begin
            skid_load = (state_reg == ST_FULL) && up_xfer && !dn_xfer;
            skid_clr  = flush || ((state_reg == ST_SKID) && dn_xfer);
         end

         if_id_skid_pipe_skid_entry #(
            .INS_W (INS_W),
            .PC_W  (PC_W),
            .NOP   (NOP)
         ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .clr   (skid_clr),
            .load  (skid_load),
            .d_ins (in_ins),
            .d_pc  (in_pc),
            .valid (skid_valid),
            .ins   (skid_ins),
            .pc    (skid_pc)
         );

         // Registered ready: decoded from state only, no path from out_ready.
         assign in_ready = (state_reg != ST_SKID);
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_ins   = NOP;
         assign skid_pc    = '0;
         // Single entry: accept when empty or when the held entry leaves now.
         assign in_ready   = !main_valid || out_ready;
      end
   endgenerate

   // Bubble counter next value: count empty cycles, stick at all-ones.
   always_comb begin
      bubble_next = bubble_reg;
      if (!main_valid && (bubble_reg != {CNT_W{1'b1}}))
         bubble_next = bubble_reg + CNT_W'(1);
   end

   // Bubble counter register.
   always_ff @(posedge clk) begin
      if (rst)
         bubble_reg <= '0;
      else
         bubble_reg <= bubble_next;
   end

endmodule

// File: tb/tb_if_id_skid_pipe.sv
// Directed bench for if_id_skid_pipe: default skid build (a), a 3-bit
// bubble counter build sharing a's stimulus (b), and a single-entry build (c).
module tb_if_id_skid_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_ins, in_pc;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_out_ins, a_out_pc;
   logic [15:0] a_bubble;

   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_ins, b_out_pc;
   logic [2:0]  b_bubble;

   logic        c_flush, c_in_valid, c_out_ready;
   logic [31:0] c_in_ins, c_in_pc;
   logic        c_in_ready, c_out_valid;
   logic [31:0] c_out_ins, c_out_pc;
   logic [15:0] c_bubble;

   int total = 0;
   int bad   = 0;

   if_id_skid_pipe u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_ins(in_ins), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_ins(a_out_ins),
      .out_pc(a_out_pc), .bubble_cnt(a_bubble)
   );

   if_id_skid_pipe #(.CNT_W(3)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_ins(in_ins), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_ins(b_out_ins),
      .out_pc(b_out_pc), .bubble_cnt(b_bubble)
   );

   if_id_skid_pipe #(.SKID_EN(0)) u_c (
      .clk(clk), .rst(rst), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ins(c_in_ins), .in_pc(c_in_pc),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ins(c_out_ins),
      .out_pc(c_out_pc), .bubble_cnt(c_bubble)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic offer_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid = v;
      in_ins   = ins;
      in_pc    = pc;
   endtask

   task automatic offer_c(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      c_in_valid = v;
      c_in_ins   = ins;
      c_in_pc    = pc;
   endtask

   // One line per downstream transfer.
   always @(posedge clk) begin
      if (!rst && a_out_valid && out_ready)
         $display("xfer a ins=%h pc=%h", a_out_ins, a_out_pc);
      if (!rst && c_out_valid && c_out_ready)
         $display("xfer c ins=%h pc=%h", c_out_ins, c_out_pc);
   end

   logic [31:0] s_ins [3];

   initial begin
      s_ins[0] = 32'h00A0_0093;
      s_ins[1] = 32'h00B0_0113;
      s_ins[2] = 32'h00C0_0193;

      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      offer_a(1'b0, 32'h0, 32'h0);
      c_flush = 1'b0; c_out_ready = 1'b0;
      offer_c(1'b0, 32'h0, 32'h0);
      step(); step();

      // reset state
      check("rst_valid", a_out_valid, 0);
      check("rst_ins",   a_out_ins,   0);
      check("rst_pc",    a_out_pc,    0);
      check("rst_ready", a_in_ready,  1);
      check("rst_bub",   a_bubble,    0);

      // idle 5 cycles
      rst = 1'b0;
      repeat (5) step();
      check("idle_valid", a_out_valid, 0);
      check("idle_ins",   a_out_ins,   0);
      check("idle_ready", a_in_ready,  1);
      check("idle_bub",   a_bubble,    5);
      check("idle_bub_b", b_bubble,    5);

      // streaming at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer_a(1'b1, s_ins[i], 32'(4 * i));
         step();
         check("str_valid", a_out_valid, 1);
         check("str_ins",   a_out_ins,   s_ins[i]);
         check("str_pc",    a_out_pc,    64'(4 * i));
      end
      offer_a(1'b0, 32'h0, 32'h0);
      step();
      check("str_drain", a_out_valid, 0);
      check("str_bub",   a_bubble,    6);

      // stall fills the skid, then drain in order
      out_ready = 1'b0;
      offer_a(1'b1, 32'h11, 32'h10);
      step();
      check("st1_ins",   a_out_ins,  32'h11);
      check("st1_ready", a_in_ready, 1);
      offer_a(1'b1, 32'h22, 32'h14);
      step();
      check("st2_ins",   a_out_ins,  32'h11);
      check("st2_ready", a_in_ready, 0);
      offer_a(1'b1, 32'h33, 32'h18);
      step();
      check("st3_ins",   a_out_ins,  32'h11);
      check("st3_ready", a_in_ready, 0);
      out_ready = 1'b1;
      step();
      check("st4_ins",   a_out_ins,  32'h22);
      check("st4_pc",    a_out_pc,   32'h14);
      check("st4_ready", a_in_ready, 1);
      step();
      check("st5_ins",   a_out_ins,  32'h33);
      check("st5_pc",    a_out_pc,   32'h18);
      offer_a(1'b0, 32'h0, 32'h0);
      step();
      check("st6_valid", a_out_valid, 0);
      check("st6_bub",   a_bubble,    7);

      // flush while in SKID with input offered
      out_ready = 1'b0;
      offer_a(1'b1, 32'h44, 32'h20);
      step();
      offer_a(1'b1, 32'h55, 32'h24);
      step();
      check("fl_skid_ready", a_in_ready, 0);
      flush = 1'b1;
      offer_a(1'b1, 32'h66, 32'h28);
      step();
      check("fl_valid", a_out_valid, 0);
      check("fl_ins",   a_out_ins,   0);
      check("fl_pc",    a_out_pc,    0);
      check("fl_ready", a_in_ready,  1);
      flush = 1'b0;
      out_ready = 1'b1;
      offer_a(1'b0, 32'h0, 32'h0);
      step();
      check("fl_after_valid", a_out_valid, 0);
      check("fl_after_bub",   a_bubble,    9);

      // flush discards a simultaneous input transfer
      flush = 1'b1;
      offer_a(1'b1, 32'h77, 32'h2c);
      step();
      check("fl_in_valid", a_out_valid, 0);
      check("fl_in_bub",   a_bubble,    10);
      flush = 1'b0;
      offer_a(1'b0, 32'h0, 32'h0);

      // reset together with flush while in SKID
      out_ready = 1'b0;
      offer_a(1'b1, 32'h88, 32'h30);
      step();
      offer_a(1'b1, 32'h99, 32'h34);
      step();
      check("rs_skid_ready", a_in_ready, 0);
      check("rs_skid_bub",   a_bubble,   11);
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      step();
      check("rs_valid", a_out_valid, 0);
      check("rs_ins",   a_out_ins,   0);
      check("rs_pc",    a_out_pc,    0);
      check("rs_ready", a_in_ready,  1);
      check("rs_bub",   a_bubble,    0);
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      offer_a(1'b0, 32'h0, 32'h0);

      // 3-bit bubble counter saturates at 7
      repeat (6) step();
      check("sat6_b", b_bubble, 6);
      step();
      check("sat7_b", b_bubble, 7);
      repeat (3) step();
      check("sat10_b", b_bubble, 7);
      check("sat10_a", a_bubble, 10);

      // single-entry build: combinational ready, no loss
      c_out_ready = 1'b0;
      offer_c(1'b1, 32'h11, 32'h40);
      #1;
      check("c_ready_empty", c_in_ready, 1);
      step();
      check("c1_ins",   c_out_ins,  32'h11);
      check("c1_ready", c_in_ready, 0);
      offer_c(1'b1, 32'h22, 32'h44);
      step();
      check("c2_ins", c_out_ins, 32'h11);
      check("c2_pc",  c_out_pc,  32'h40);
      c_out_ready = 1'b1;
      #1;
      check("c_ready_follow", c_in_ready, 1);
      step();
      check("c3_ins", c_out_ins, 32'h22);
      check("c3_pc",  c_out_pc,  32'h44);
      offer_c(1'b1, 32'h33, 32'h48);
      step();
      check("c4_ins", c_out_ins, 32'h33);
      offer_c(1'b0, 32'h0, 32'h0);
      step();
      check("c5_valid", c_out_valid, 0);
      c_out_ready = 1'b0;
      #1;
      check("c_ready_idle", c_in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
